// File: rtl/cpu_seq_pkg.sv
// Shared state encoding and fixed T-state indices for the CPU timing sequencer.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        BOOT,
        FETCH_LO,
        FETCH_HI,
        DECODE,
        EXEC,
        HALT
    } seq_state_t;

    localparam int unsigned T_FETCH_LO = 0;
    localparam int unsigned T_FETCH_HI = 1;
    localparam int unsigned T_DECODE   = 2;

endpackage

// File: rtl/seq_wait_timer.sv
// Saturating count of consecutive fetch stall cycles; flags the WAIT_MAX-th stall.
module seq_wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic stall,
    output logic timeout
);

    localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    logic [CNT_W-1:0] count;

    // count holds the stalls already seen, so the limit hits on the WAIT_MAX-th one
    assign timeout = (WAIT_MAX != 0) && stall && (count == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (!stall || timeout) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_timing_sequencer.sv
// T-state / fetch-control sequencer for the multi-cycle CPU control unit.
// Optional memory wait-state handshake and bus timeout: define SEQ_WAIT_EN.
module cpu_timing_sequencer
    import cpu_seq_pkg::*;
#(
    parameter  int unsigned T_WIDTH       = 12,
    parameter  int unsigned DECODE_CYCLES = 1,
    parameter  int unsigned WAIT_MAX      = 15,
    localparam int unsigned STEP_W        = $clog2(T_WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               End_Req,
    input  logic               Halt_Req,
    input  logic               Resume,
    input  logic               Mem_Ready,
    output logic [T_WIDTH-1:0] T,
    output logic [STEP_W-1:0]  Step,
    output logic               T_Reset,
    output logic               Exec_En,
    output logic               Mem_CS,
    output logic               IR_Write,
    output logic               IR_LH,
    output logic               PC_Inc,
    output logic               Halted,
    output logic               Step_Fault,
    output logic               Bus_Fault
);

    seq_state_t        state, state_nxt;
    logic [STEP_W-1:0] step, step_nxt;
    logic              fresh, fresh_nxt;
    logic              step_fault, set_step_fault;
    logic              boundary;
    logic              stall, timeout;

`ifdef SEQ_WAIT_EN
    logic in_fetch;
    logic bus_fault;

    assign in_fetch = (state == FETCH_LO) || (state == FETCH_HI);
    assign stall    = in_fetch && !Mem_Ready;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .stall   (stall),
        .timeout (timeout)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) bus_fault <= 1'b0;
        else        bus_fault <= bus_fault | timeout;
    end

    assign Bus_Fault = bus_fault;
`else
    localparam int unsigned unused_wait_max = WAIT_MAX;
    logic unused_mem_ready;

    assign unused_mem_ready = Mem_Ready;
    assign stall            = 1'b0;
    assign timeout          = 1'b0;
    assign Bus_Fault        = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= BOOT;
            step       <= '0;
            fresh      <= 1'b0;
            step_fault <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            fresh      <= fresh_nxt;
            step_fault <= step_fault | set_step_fault;
        end
    end

    always_comb begin
        state_nxt      = state;
        step_nxt       = step;
        fresh_nxt      = 1'b0;
        set_step_fault = 1'b0;
        boundary       = 1'b0;
        unique case (state)
            BOOT: begin
                state_nxt = FETCH_LO;
                step_nxt  = STEP_W'(T_FETCH_LO);
            end
            FETCH_LO: begin
                if (timeout) begin
                    step_nxt  = STEP_W'(T_FETCH_LO);
                    fresh_nxt = 1'b1;
                end else if (!stall) begin
                    state_nxt = FETCH_HI;
                    step_nxt  = STEP_W'(T_FETCH_HI);
                end
            end
            FETCH_HI: begin
                if (timeout) begin
                    state_nxt = FETCH_LO;
                    step_nxt  = STEP_W'(T_FETCH_LO);
                    fresh_nxt = 1'b1;
                end else if (!stall) begin
                    state_nxt = (DECODE_CYCLES != 0) ? DECODE : EXEC;
                    step_nxt  = STEP_W'(T_DECODE);
                end
            end
            DECODE: begin
                if (End_Req) begin
                    boundary = 1'b1;
                end else begin
                    state_nxt = EXEC;
                    step_nxt  = step + 1'b1;
                end
            end
            EXEC: begin
                if (End_Req) begin
                    boundary = 1'b1;
                end else if (step == STEP_W'(T_WIDTH - 1)) begin
                    boundary       = 1'b1;
                    set_step_fault = 1'b1;
                end else begin
                    step_nxt = step + 1'b1;
                end
            end
            HALT: begin
                if (Resume) begin
                    state_nxt = FETCH_LO;
                    step_nxt  = STEP_W'(T_FETCH_LO);
                    fresh_nxt = 1'b1;
                end
            end
            default: state_nxt = BOOT;
        endcase

        // Instruction boundary, whether closed by decode or by the forced wrap
        if (boundary) begin
            step_nxt = STEP_W'(T_FETCH_LO);
            if (Halt_Req && !Resume) begin
                state_nxt = HALT;
            end else begin
                state_nxt = FETCH_LO;
                fresh_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        T        = '0;
        Step     = '0;
        T_Reset  = 1'b0;
        Exec_En  = 1'b0;
        Mem_CS   = 1'b1;
        IR_Write = 1'b0;
        IR_LH    = 1'b0;
        PC_Inc   = 1'b0;
        Halted   = 1'b0;
        unique case (state)
            BOOT: T_Reset = 1'b1;
            FETCH_LO, FETCH_HI: begin
                T[step]  = 1'b1;
                Step     = step;
                T_Reset  = fresh;
                Mem_CS   = 1'b0;
                IR_Write = !stall;
                PC_Inc   = !stall;
                IR_LH    = (state == FETCH_HI);
            end
            DECODE: begin
                T[step] = 1'b1;
                Step    = step;
            end
            EXEC: begin
                T[step] = 1'b1;
                Step    = step;
                Exec_En = 1'b1;
            end
            HALT:    Halted = 1'b1;
            default: T_Reset = 1'b1;
        endcase
    end

    assign Step_Fault = step_fault;

endmodule
